// File: rtl/fetch_pkg.sv
// Shared constants for the instruction fetch queue: FSM encoding and widths.
package fetch_pkg;

  localparam int XLEN_DEFAULT = 32;
  localparam int INSTR_W      = 32;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_F_REQ  = 3'd1;
  localparam logic [2:0] S_F_WAIT = 3'd2;
  localparam logic [2:0] S_L_REQ  = 3'd3;
  localparam logic [2:0] S_L_WAIT = 3'd4;

  function automatic logic isFetchState(input logic [2:0] s);
    return (s == S_F_REQ) || (s == S_F_WAIT);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Circular-buffer queue of fetched {pc, instruction} entries with synchronous flush.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     pClk,
  input  logic                     pReset,
  input  logic                     pPush,
  input  logic                     pPop,
  input  logic                     pFlush,
  input  logic [WIDTH-1:0]         pWrData,
  output logic [WIDTH-1:0]         pRdData,
  output logic                     pFull,
  output logic                     pEmpty,
  output logic [$clog2(DEPTH):0]   pCount
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rdPtr;
  logic [PTR_W-1:0] wrPtr;
  logic [CNT_W-1:0] count;
  logic             doPush;
  logic             doPop;

  function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign doPush = pPush && !pFull;
  assign doPop  = pPop && !pEmpty;

  always_ff @(posedge pClk) begin
    if (pReset || pFlush) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= nextPtr(wrPtr);
      if (doPop)  rdPtr <= nextPtr(rdPtr);
      case ({doPush, doPop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; the pointers decide what is valid.
  always_ff @(posedge pClk) begin
    if (doPush) mem[wrPtr] <= pWrData;
  end

  assign pRdData = mem[rdPtr];
  assign pFull   = (count == CNT_W'(DEPTH));
  assign pEmpty  = (count == '0);
  assign pCount  = count;

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction prefetcher sharing one memory port with loads; fetched words feed
// decode through a small queue, and redirects flush it and restart fetch.
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEFAULT,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            pClk,
  input  logic            pReset,
  input  logic            pRedirect,
  input  logic [XLEN-1:0] pRedirectPC,
  input  logic            pLsReq,
  input  logic [XLEN-1:0] pLsAddr,
  output logic [XLEN-1:0] pLsRData,
  output logic            pLsDone,
  output logic            pMemReq,
  output logic [XLEN-1:0] pMemAddr,
  input  logic            pMemAck,
  input  logic            pMemRValid,
  input  logic [XLEN-1:0] pMemRData,
  output logic            pOutValid,
  input  logic            pOutReady,
  output logic [XLEN-1:0] pOutInstr,
  output logic [XLEN-1:0] pOutPC,
  output logic [XLEN-1:0] pOutPCPlus4,
  output logic [2:0]      pDbgState
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  // Handshakes: pMemReq/pMemAddr hold until the cycle pMemAck is high (the
  // transfer); decode takes the head entry in any cycle pOutValid && pOutReady.

  logic [2:0]        state;
  logic [XLEN-1:0]   fetchPC;
  logic [XLEN-1:0]   memAddr;
  logic [XLEN-1:0]   lsRData;
  logic              lsDone;
  logic              dropFlag;
  logic              fetchResp;
  logic              roomForFetch;
  logic              fifoPush;
  logic              fifoPop;
  logic              fifoFull;
  logic              fifoEmpty;
  logic [CNT_W-1:0]  fifoCount;
  logic [2*XLEN-1:0] fifoWrData;
  logic [2*XLEN-1:0] fifoRdData;
  logic              unusedLowBits;

  assign unusedLowBits = ^{pLsAddr[1:0], pRedirectPC[1:0]};

  assign fetchResp    = (state == S_F_WAIT) && pMemRValid;
  assign roomForFetch = (fifoCount < CNT_W'(DEPTH));
  assign fifoPush     = fetchResp && !dropFlag && !pRedirect && !fifoFull;
  assign fifoPop      = pOutValid && pOutReady;
  assign fifoWrData   = {fetchPC, pMemRData};

  fetch_fifo #(
    .WIDTH (2 * XLEN),
    .DEPTH (DEPTH)
  ) uFifo (
    .pClk    (pClk),
    .pReset  (pReset),
    .pPush   (fifoPush),
    .pPop    (fifoPop),
    .pFlush  (pRedirect),
    .pWrData (fifoWrData),
    .pRdData (fifoRdData),
    .pFull   (fifoFull),
    .pEmpty  (fifoEmpty),
    .pCount  (fifoCount)
  );

  always_ff @(posedge pClk) begin
    if (pReset) begin
      state    <= S_IDLE;
      fetchPC  <= RESET_PC;
      memAddr  <= '0;
      dropFlag <= 1'b0;
      lsDone   <= 1'b0;
      lsRData  <= '0;
    end else begin
      lsDone <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pLsReq) begin
            state   <= S_L_REQ;
            memAddr <= {pLsAddr[XLEN-1:2], 2'b00};
          end else if (!pRedirect && roomForFetch) begin
            // A redirect this cycle would make fetchPC stale; start next cycle.
            state   <= S_F_REQ;
            memAddr <= fetchPC;
          end
        end
        S_F_REQ:  if (pMemAck) state <= S_F_WAIT;
        S_F_WAIT: if (pMemRValid) state <= S_IDLE;
        S_L_REQ:  if (pMemAck) state <= S_L_WAIT;
        S_L_WAIT: begin
          if (pMemRValid) begin
            state   <= S_IDLE;
            lsRData <= pMemRData;
            lsDone  <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase

      if (pRedirect)     fetchPC <= {pRedirectPC[XLEN-1:2], 2'b00};
      else if (fifoPush) fetchPC <= fetchPC + XLEN'(4);

      if (fetchResp)                             dropFlag <= 1'b0;
      else if (pRedirect && isFetchState(state)) dropFlag <= 1'b1;
    end
  end

  assign pMemReq     = (state == S_F_REQ) || (state == S_L_REQ);
  assign pMemAddr    = memAddr;
  assign pLsRData    = lsRData;
  assign pLsDone     = lsDone;
  assign pOutValid   = !fifoEmpty;
  assign pOutInstr   = fifoEmpty ? '0 : fifoRdData[XLEN-1:0];
  assign pOutPC      = fifoEmpty ? '0 : fifoRdData[2*XLEN-1:XLEN];
  assign pOutPCPlus4 = pOutPC + XLEN'(4);
  assign pDbgState   = state;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: fill/drain table, redirect, load, wrap, reset.
module tb_instr_fetch_queue;
  import fetch_pkg::*;

  logic        pClk;
  logic        pReset;
  logic        pRedirect;
  logic [31:0] pRedirectPC;
  logic        pLsReq;
  logic [31:0] pLsAddr;
  logic [31:0] pLsRData;
  logic        pLsDone;
  logic        pMemReq;
  logic [31:0] pMemAddr;
  logic        pMemAck;
  logic        pMemRValid;
  logic [31:0] pMemRData;
  logic        pOutValid;
  logic        pOutReady;
  logic [31:0] pOutInstr;
  logic [31:0] pOutPC;
  logic [31:0] pOutPCPlus4;
  logic [2:0]  pDbgState;

  instr_fetch_queue dut (
    .pClk        (pClk),
    .pReset      (pReset),
    .pRedirect   (pRedirect),
    .pRedirectPC (pRedirectPC),
    .pLsReq      (pLsReq),
    .pLsAddr     (pLsAddr),
    .pLsRData    (pLsRData),
    .pLsDone     (pLsDone),
    .pMemReq     (pMemReq),
    .pMemAddr    (pMemAddr),
    .pMemAck     (pMemAck),
    .pMemRValid  (pMemRValid),
    .pMemRData   (pMemRData),
    .pOutValid   (pOutValid),
    .pOutReady   (pOutReady),
    .pOutInstr   (pOutInstr),
    .pOutPC      (pOutPC),
    .pOutPCPlus4 (pOutPCPlus4),
    .pDbgState   (pDbgState)
  );

  initial begin
    pClk = 1'b0;
    forever #5 pClk = ~pClk;
  end

  int          total = 0;
  int          bad   = 0;
  logic        memAuto = 1'b0;
  logic [31:0] ackAddr = '0;
  logic [31:0] reqLog[$];
  logic [31:0] expQ[$];

  typedef struct {
    logic        ready;
    logic        expValid;
    logic [31:0] expPC;
    logic [31:0] expPC4;
    logic        expMemReq;
    logic [31:0] expMemAddr;
  } vec_t;

  vec_t vecs[5];

  function automatic logic [31:0] instrOf(input logic [31:0] a);
    return a ^ 32'h1357_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  // When memAuto is set, memory acks any request at once and answers next cycle.
  task automatic step();
    @(posedge pClk);
    #1;
    if (memAuto) begin
      pMemRValid = pMemAck;
      pMemRData  = instrOf(ackAddr);
      pMemAck    = pMemReq;
      if (pMemReq) begin
        ackAddr = pMemAddr;
        reqLog.push_back(pMemAddr);
      end
    end
  endtask

  task automatic checkLog(input string name);
    chk({name, "_count"}, 32'(reqLog.size()), 32'(expQ.size()));
    for (int i = 0; i < expQ.size(); i++) begin
      if (i < reqLog.size()) chk($sformatf("%s_%0d", name, i), reqLog[i], expQ[i]);
    end
  endtask

  int          doneCnt;
  logic [31:0] lsData;

  initial begin
    pReset = 1'b1; pRedirect = 1'b0; pRedirectPC = '0; pLsReq = 1'b0; pLsAddr = '0;
    pMemAck = 1'b0; pMemRValid = 1'b0; pMemRData = '0; pOutReady = 1'b0;

    vecs[0] = '{1'b1, 1'b1, 32'h4,  32'h8,  1'b0, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 32'h8,  32'hC,  1'b0, 32'h0};
    vecs[2] = '{1'b1, 1'b1, 32'hC,  32'h10, 1'b1, 32'h14};
    vecs[3] = '{1'b0, 1'b1, 32'h10, 32'h14, 1'b1, 32'h14};
    vecs[4] = '{1'b0, 1'b1, 32'h10, 32'h14, 1'b1, 32'h14};

    // Reset values
    repeat (3) step();
    chk("rst_memreq", 32'(pMemReq), 32'd0);
    chk("rst_outvalid", 32'(pOutValid), 32'd0);
    chk("rst_lsdone", 32'(pLsDone), 32'd0);
    chk("rst_lsrdata", pLsRData, 32'h0);
    chk("rst_instr", pOutInstr, 32'h0);
    chk("rst_pc", pOutPC, 32'h0);
    chk("rst_state", 32'(pDbgState), 32'(S_IDLE));

    // Fill the queue with decode stalled
    pReset = 1'b0;
    memAuto = 1'b1;
    repeat (20) step();
    expQ.delete();
    expQ.push_back(32'h0); expQ.push_back(32'h4); expQ.push_back(32'h8); expQ.push_back(32'hC);
    checkLog("fill");
    chk("fill_memreq_idle", 32'(pMemReq), 32'd0);
    chk("fill_valid", 32'(pOutValid), 32'd1);
    chk("fill_pc", pOutPC, 32'h0);
    chk("fill_pc4", pOutPCPlus4, 32'h4);
    chk("fill_instr", pOutInstr, instrOf(32'h0));

    // One pop while full -> exactly one refill at 16
    pOutReady = 1'b1;
    step();
    pOutReady = 1'b0;
    repeat (10) step();
    expQ.push_back(32'h10);
    checkLog("refill");
    chk("refill_pc", pOutPC, 32'h4);
    chk("refill_memreq", 32'(pMemReq), 32'd0);

    // Drain table with memory stalled
    memAuto = 1'b0;
    pMemAck = 1'b0;
    pMemRValid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      pOutReady = vecs[i].ready;
      chk($sformatf("vec%0d_valid", i), 32'(pOutValid), 32'(vecs[i].expValid));
      chk($sformatf("vec%0d_pc", i), pOutPC, vecs[i].expPC);
      chk($sformatf("vec%0d_pc4", i), pOutPCPlus4, vecs[i].expPC4);
      chk($sformatf("vec%0d_instr", i), pOutInstr, instrOf(vecs[i].expPC));
      chk($sformatf("vec%0d_memreq", i), 32'(pMemReq), 32'(vecs[i].expMemReq));
      if (vecs[i].expMemReq) chk($sformatf("vec%0d_memaddr", i), pMemAddr, vecs[i].expMemAddr);
      step();
    end

    // Redirect during F_WAIT drops the in-flight response
    pMemAck = 1'b1;
    step();
    pMemAck = 1'b0;
    pRedirect = 1'b1;
    pRedirectPC = 32'h103;
    chk("redir_state_fwait", 32'(pDbgState), 32'(S_F_WAIT));
    chk("redir_valid_before", 32'(pOutValid), 32'd1);
    step();
    pRedirect = 1'b0;
    pMemRValid = 1'b1;
    pMemRData = 32'hDEADBEEF;
    chk("redir_flushed", 32'(pOutValid), 32'd0);
    step();
    pMemRValid = 1'b0;
    chk("redir_dropped", 32'(pOutValid), 32'd0);
    chk("redir_state_idle", 32'(pDbgState), 32'(S_IDLE));
    step();
    chk("redir_memreq", 32'(pMemReq), 32'd1);
    chk("redir_addr", pMemAddr, 32'h100);
    memAuto = 1'b1;
    reqLog.delete();
    repeat (15) step();
    chk("redir_head_pc", pOutPC, 32'h100);
    chk("redir_head_instr", pOutInstr, instrOf(32'h100));

    // Load takes priority over a pending fetch
    pRedirect = 1'b1;
    pRedirectPC = 32'h300;
    chk("ld_pre_idle", 32'(pDbgState), 32'(S_IDLE));
    step();
    pRedirect = 1'b0;
    pLsReq = 1'b1;
    pLsAddr = 32'h2000;
    reqLog.delete();
    chk("ld_idle", 32'(pDbgState), 32'(S_IDLE));
    chk("ld_empty", 32'(pOutValid), 32'd0);
    step();
    pLsReq = 1'b0;
    chk("ld_memreq", 32'(pMemReq), 32'd1);
    chk("ld_addr", pMemAddr, 32'h2000);
    doneCnt = 0;
    lsData = '0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (pLsDone) begin
        doneCnt++;
        lsData = pLsRData;
      end
    end
    chk("ld_done_pulses", 32'(doneCnt), 32'd1);
    chk("ld_data", lsData, instrOf(32'h2000));
    chk("ld_rdata_held", pLsRData, instrOf(32'h2000));
    chk("ld_first_req", reqLog.size() > 0 ? reqLog[0] : 32'hFFFF_FFFF, 32'h2000);
    chk("ld_fetch_resume", reqLog.size() > 1 ? reqLog[1] : 32'hFFFF_FFFF, 32'h300);

    // Fetch PC wraps past the top of the address space
    pRedirect = 1'b1;
    pRedirectPC = 32'hFFFF_FFFC;
    reqLog.delete();
    step();
    pRedirect = 1'b0;
    repeat (20) step();
    expQ.delete();
    expQ.push_back(32'hFFFF_FFFC); expQ.push_back(32'h0); expQ.push_back(32'h4); expQ.push_back(32'h8);
    checkLog("wrap");
    chk("wrap_pc", pOutPC, 32'hFFFF_FFFC);
    chk("wrap_pc4", pOutPCPlus4, 32'h0);
    chk("wrap_instr", pOutInstr, instrOf(32'hFFFF_FFFC));

    // Reset during L_WAIT, overriding redirect/load; late response ignored
    memAuto = 1'b0;
    pMemAck = 1'b0;
    pMemRValid = 1'b0;
    chk("rl_pre_idle", 32'(pDbgState), 32'(S_IDLE));
    pLsReq = 1'b1;
    pLsAddr = 32'h2004;
    step();
    pLsReq = 1'b0;
    pMemAck = 1'b1;
    chk("rl_lreq", 32'(pDbgState), 32'(S_L_REQ));
    chk("rl_addr", pMemAddr, 32'h2004);
    step();
    pMemAck = 1'b0;
    pReset = 1'b1;
    pRedirect = 1'b1;
    pRedirectPC = 32'h500;
    pLsReq = 1'b1;
    chk("rl_lwait", 32'(pDbgState), 32'(S_L_WAIT));
    step();
    pReset = 1'b0;
    pRedirect = 1'b0;
    pLsReq = 1'b0;
    pMemRValid = 1'b1;
    pMemRData = 32'hCAFE_F00D;
    chk("rl_state_idle", 32'(pDbgState), 32'(S_IDLE));
    chk("rl_lsdone0", 32'(pLsDone), 32'd0);
    chk("rl_empty0", 32'(pOutValid), 32'd0);
    step();
    pMemRValid = 1'b0;
    chk("rl_lsdone1", 32'(pLsDone), 32'd0);
    chk("rl_lsrdata", pLsRData, 32'h0);
    chk("rl_empty1", 32'(pOutValid), 32'd0);
    chk("rl_memreq", 32'(pMemReq), 32'd1);
    chk("rl_addr_resetpc", pMemAddr, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
